pwm_capture: RTL and testbench

Input-capture companion to the team's timer/PWM generator. It measures an external PWM waveform's period and high time in prescaled ticks and reports each completed period with a one-cycle valid strobe. It is used for loopback verification of the timer and for reading external PWM or tachometer signals. Pin input is asynchronous; everything else runs on one clock.

---
 rtl/pwm_capture.sv | 142 ++++++++++++++
 tb/tb_pwm_capture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: input-capture unit that measures an external PWM waveform.
//   Reports period (rising-to-rising) and high time (rising-to-falling) in
//   prescaled ticks with a one-cycle valid strobe.
// Ports:
//   clk, rst         - system clock, async active-high reset
//   prescaler_cnt    - tick divider (tick = clk/(prescaler_cnt+1)), latched on go rise
//   go               - enable; low forces IDLE
//   pwm_in           - asynchronous pin input
//   period/high_time - last captured values, in ticks (saturating, never wrap)
//   valid            - one-cycle strobe when period/high_time update
//   overflow         - sticky: counter saturated before the next rising edge
//   busy             - state is ARM or MEASURE
module pwm_capture #(
  parameter int PRESCALER_BITS = 8,
  parameter int TIMER_BITS     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESCALER_BITS-1:0] prescaler_cnt,
  input  logic                      go,
  input  logic                      pwm_in,
  output logic [TIMER_BITS-1:0]     period,
  output logic [TIMER_BITS-1:0]     high_time,
  output logic                      valid,
  output logic                      overflow,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_nx;

  logic s1, s2, s3, go_d;
  logic [PRESCALER_BITS-1:0] prescaler_n, prescaler_l;
  logic [TIMER_BITS-1:0]     count, hi_l;
  logic                      overflow_run;
  logic                      rise, fall, tick, go_rise;
  logic [TIMER_BITS:0]       count_inc;
  logic [TIMER_BITS-1:0]     cap;

  function automatic logic [TIMER_BITS-1:0] sat(input logic [TIMER_BITS:0] v);
    return v[TIMER_BITS] ? '1 : v[TIMER_BITS-1:0];
  endfunction

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign tick      = (prescaler_n == prescaler_l);
  assign go_rise   = go & ~go_d;
  // One bit of headroom so the saturation test is a single carry bit.
  assign count_inc = {1'b0, count} + {{TIMER_BITS{1'b0}}, tick};
  assign cap       = sat(count_inc);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go_rise) state_nx = ARM;
      ARM:     if (rise)    state_nx = MEASURE;
      MEASURE: state_nx = MEASURE;
      default: state_nx = IDLE;
    endcase
    // go low overrides everything, including a coincident rising edge.
    if (!go) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      // go history comes out of reset as "high" so a go held through reset
      // does not count as a rising edge; it has to drop and rise again.
      go_d         <= 1'b1;
      prescaler_n  <= '0;
      prescaler_l  <= '0;
      count        <= '0;
      hi_l         <= '0;
      period       <= '0;
      high_time    <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      overflow_run <= 1'b0;
    end else begin
      s1    <= pwm_in;
      s2    <= s1;
      s3    <= s2;
      go_d  <= go;
      valid <= 1'b0;
      if (!go) begin
        prescaler_n  <= '0;
        overflow     <= 1'b0;
        overflow_run <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            prescaler_n <= '0;
            if (go_rise) begin
              prescaler_l  <= prescaler_cnt;
              count        <= '0;
              overflow     <= 1'b0;
              overflow_run <= 1'b0;
            end
          end
          ARM: begin
            prescaler_n <= tick ? '0 : prescaler_n + {{(PRESCALER_BITS-1){1'b0}}, 1'b1};
            // First partial period is dropped; measurement starts here.
            if (rise) count <= '0;
          end
          MEASURE: begin
            prescaler_n <= tick ? '0 : prescaler_n + {{(PRESCALER_BITS-1){1'b0}}, 1'b1};
            if (fall) hi_l <= cap;
            if (rise) begin
              count        <= '0;
              overflow_run <= 1'b0;
              // A period that saturated is discarded; overflow stays sticky
              // until a clean period is reported.
              if (!overflow_run) begin
                period    <= cap;
                high_time <= hi_l;
                valid     <= 1'b1;
                overflow  <= 1'b0;
              end
            end else if (tick) begin
              if (count_inc[TIMER_BITS]) begin
                overflow     <= 1'b1;
                overflow_run <= 1'b1;
              end else begin
                count <= count_inc[TIMER_BITS-1:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (TIMER_BITS=8 so overflow is reachable).
// Expected captures are queued as stimulus is driven; a negedge monitor pops
// and compares on every valid strobe.
module tb_pwm_capture;
  localparam int PB = 8;
  localparam int TB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PB-1:0] prescaler_cnt = '0;
  logic          go = 1'b0;
  logic          pwm_in = 1'b0;
  logic [TB-1:0] period, high_time;
  logic          valid, overflow, busy;

  typedef struct {
    logic [TB-1:0] period;
    logic [TB-1:0] high_time;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int v_last = 0;
  int v_prev = 0;

  pwm_capture #(.PRESCALER_BITS(PB), .TIMER_BITS(TB)) dut (
    .clk(clk), .rst(rst), .prescaler_cnt(prescaler_cnt), .go(go),
    .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .valid(valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (valid) begin
      v_prev = v_last;
      v_last = cyc;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid: got valid with period=%0d high_time=%0d, required no valid", period, high_time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (period !== e.period) begin
          failures++;
          $display("FAIL period: got %0d, required %0d", period, e.period);
        end
        checks++;
        if (high_time !== e.high_time) begin
          failures++;
          $display("FAIL high_time: got %0d, required %0d", high_time, e.high_time);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int p, input int h, input int n);
    exp_t e;
    e.period = p[TB-1:0];
    e.high_time = h[TB-1:0];
    repeat (n) exp_q.push_back(e);
  endtask

  // n full periods then a final rising edge, held high a few cycles
  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      pwm_in = 1'b1; cycles(h);
      pwm_in = 1'b0; cycles(l);
    end
    pwm_in = 1'b1; cycles(8);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d captures outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start(input int pre);
    go = 1'b0; pwm_in = 1'b0; cycles(3);
    prescaler_cnt = pre[PB-1:0];
    go = 1'b1; cycles(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; cycles(2);
    checks += 5;
    if (period !== 0)    begin failures++; $display("FAIL reset_period: got %0d, required 0", period); end
    if (high_time !== 0) begin failures++; $display("FAIL reset_high_time: got %0d, required 0", high_time); end
    if (valid !== 0)     begin failures++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    if (overflow !== 0)  begin failures++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
    if (busy !== 0)      begin failures++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    rst = 1'b0; cycles(2);
  endtask

  task automatic test_basic();
    start(0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b, required 1", busy); end
    push(25, 10, 4);
    wave(10, 15, 4);
    drain("basic");
  endtask

  task automatic test_prescaler();
    start(3);
    push(10, 3, 3);
    wave(12, 28, 3);
    drain("prescaler");
    checks++;
    if (v_last - v_prev != 40) begin
      failures++; $display("FAIL prescaler_spacing: got %0d clk, required 40", v_last - v_prev);
    end
  endtask

  task automatic test_loopback();
    start(0);
    push(20, 8, 3);
    wave(8, 12, 3);
    drain("loopback");
  endtask

  task automatic test_overflow();
    bit seen;
    start(0);
    pwm_in = 1'b1; cycles(5);
    pwm_in = 1'b0; cycles(200);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %0b, required 0", overflow); end
    cycles(100);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %0b, required 1", overflow); end
    // rise that ends the saturated run: discarded
    pwm_in = 1'b1; cycles(10);
    pwm_in = 1'b0; cycles(15);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0b, required 1", overflow); end
    push(25, 10, 1);
    pwm_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_with_valid: got %0b, required 0", overflow); end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL ovf_valid_timeout: got no valid, required valid"); end
    cycles(3);
    drain("overflow");
  endtask

  task automatic test_go_drop();
    start(0);
    push(30, 12, 1);
    wave(12, 18, 1);
    drain("go_drop_pre");
    cycles(4);               // mid high phase of a new period
    go = 1'b0; cycles(1);
    checks += 4;
    if (busy !== 1'b0)      begin failures++; $display("FAIL go_drop_busy: got %0b, required 0", busy); end
    if (overflow !== 1'b0)  begin failures++; $display("FAIL go_drop_ovf: got %0b, required 0", overflow); end
    if (period !== 30)      begin failures++; $display("FAIL go_drop_period: got %0d, required 30", period); end
    if (high_time !== 12)   begin failures++; $display("FAIL go_drop_high: got %0d, required 12", high_time); end
    pwm_in = 1'b0; cycles(20);
    // re-arm: the first rise after go must not report
    go = 1'b1; cycles(3);
    push(30, 12, 1);
    wave(12, 18, 1);
    drain("go_rearm");
  endtask

  task automatic test_async_reset();
    start(0);
    push(25, 10, 1);
    wave(10, 15, 1);
    drain("areset_pre");
    cycles(3);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    checks += 5;
    if (period !== 0)    begin failures++; $display("FAIL areset_period: got %0d, required 0", period); end
    if (high_time !== 0) begin failures++; $display("FAIL areset_high: got %0d, required 0", high_time); end
    if (valid !== 0)     begin failures++; $display("FAIL areset_valid: got %0b, required 0", valid); end
    if (overflow !== 0)  begin failures++; $display("FAIL areset_ovf: got %0b, required 0", overflow); end
    if (busy !== 0)      begin failures++; $display("FAIL areset_busy: got %0b, required 0", busy); end
    cycles(2);
    rst = 1'b0;              // go still high: must not arm by itself
    wave(10, 15, 3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL areset_idle: got busy=%0b, required 0", busy); end
    push(25, 10, 2);
    start(0);
    pwm_in = 1'b0; cycles(5);
    wave(10, 15, 2);
    drain("areset_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescaler();
    test_loopback();
    test_overflow();
    test_go_drop();
    test_async_reset();
    go = 1'b0; cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
